act_pingpong_memory: RTL and testbench

- Double-buffered (ping-pong) activation memory with two banks, each ENTRY_NUM x DIM x DIM words of DATA_SIZE bits.
- A layer producer fills one bank while the next-layer consumer reads the other; banks swap by write_done/read_done handshakes.
- Adds bank ownership tracking, a registered read with valid, and sticky error flags for out-of-range and protocol violations.

---
 rtl/act_pingpong_memory.sv | 186 ++++++++++++++++++
 tb/tb_act_pingpong_memory.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_pingpong_memory.sv
// Double-buffered activation memory: a producer fills one bank while a
// consumer reads the other, with bank swaps by done handshakes.
module act_pingpong_memory #(
    parameter string NAME      = "DEFAULT PP ACT MEM",
    parameter int    ENTRY_NUM = 1,
    parameter int    DIM       = 1,
    parameter int    DATA_SIZE = 64,
    parameter bit    DEBUG     = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write,
    input  logic [15:0]          index_entry,
    input  logic [15:0]          index_y,
    input  logic [15:0]          index_x,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 write_done,
    output logic                 write_ready,
    output logic                 wr_bank,
    output logic [31:0]          wr_count,
    input  logic                 read_req,
    input  logic [15:0]          read_index_entry,
    input  logic [15:0]          read_index_y,
    input  logic [15:0]          read_index_x,
    input  logic                 read_done,
    output logic                 read_ready,
    output logic                 rd_bank,
    output logic [DATA_SIZE-1:0] out_data,
    output logic                 out_valid,
    output logic [1:0]           err
);

    localparam int DEPTH = ENTRY_NUM * DIM * DIM;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [31:0] ENTRY_LIM = 32'(ENTRY_NUM);
    localparam logic [31:0] DIM_LIM   = 32'(DIM);

    // Range checks on the raw 16-bit indices, widened, never truncated.
    function automatic logic in_range(
        input logic [15:0] e,
        input logic [15:0] y,
        input logic [15:0] x
    );
        return ({16'h0, e} < ENTRY_LIM) &&
               ({16'h0, y} < DIM_LIM) &&
               ({16'h0, x} < DIM_LIM);
    endfunction

    // Flat address computed at full width; only the low bits are needed
    // once the indices are known to be in range.
    function automatic logic [AW-1:0] flat_addr(
        input logic [15:0] e,
        input logic [15:0] y,
        input logic [15:0] x
    );
        logic [63:0] f;
        f = ({48'h0, e} * 64'(DIM) + {48'h0, y}) * 64'(DIM) + {48'h0, x};
        return AW'(f);
    endfunction

    logic [DATA_SIZE-1:0] mem_q [2][DEPTH];

    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [1:0]           full_q, full_d;
    logic [31:0]          wr_count_q, wr_count_d;
    logic [DATA_SIZE-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic [1:0]           err_q, err_d;

    logic          wr_in_range;
    logic          rd_in_range;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic          wr_acc;
    logic          wd_acc;
    logic          rr_acc;
    logic          rd_acc;

    assign write_ready = !full_q[wr_bank_q];
    assign read_ready  = full_q[rd_bank_q];

    assign wr_in_range = in_range(index_entry, index_y, index_x);
    assign rd_in_range = in_range(read_index_entry, read_index_y,
                                  read_index_x);
    assign waddr = flat_addr(index_entry, index_y, index_x);
    assign raddr = flat_addr(read_index_entry, read_index_y, read_index_x);

    assign wr_acc = write && write_ready && wr_in_range;
    assign wd_acc = write_done && write_ready;
    assign rr_acc = read_req && read_ready;
    assign rd_acc = read_done && read_ready;

    // Next-state for bank ownership, counters, read port and error flags.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        wr_count_d  = wr_count_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        err_d       = err_q;

        if (wd_acc) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_count_d        = 32'd0;
        end else if (wr_acc && (wr_count_q != 32'hFFFF_FFFF)) begin
            wr_count_d = wr_count_q + 32'd1;
        end

        if (rd_acc) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end

        if (rr_acc) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_in_range ? mem_q[rd_bank_q][raddr] : '0;
        end

        if ((write && write_ready && !wr_in_range) ||
            (rr_acc && !rd_in_range)) begin
            err_d[0] = 1'b1;
        end

        if ((write && !write_ready) || (write_done && !write_ready) ||
            (read_req && !read_ready) || (read_done && !read_ready)) begin
            err_d[1] = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= 2'b00;
            wr_count_q  <= 32'd0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            wr_count_q  <= wr_count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    // Storage array; contents survive reset, writes are blocked during it.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_bank_q][waddr] <= in_data;
        end
    end

    assign wr_bank   = wr_bank_q;
    assign rd_bank   = rd_bank_q;
    assign wr_count  = wr_count_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

    if (DEBUG) begin : g_debug
        // Trace accepted writes and bank swaps.
        always_ff @(posedge clk) begin
            if (!rst && wr_acc) begin
                $display("%s: write bank=%0d e=%0d y=%0d x=%0d data=%f",
                         NAME, wr_bank_q, index_entry, index_y, index_x,
                         $bitstoreal(64'(in_data)));
            end
            if (!rst && wd_acc) begin
                $display("%s: wr_bank -> %0d", NAME, !wr_bank_q);
            end
            if (!rst && rd_acc) begin
                $display("%s: rd_bank -> %0d", NAME, !rd_bank_q);
            end
        end
    end

endmodule

// File: tb/tb_act_pingpong_memory.sv
// Directed bench for the ping-pong activation memory
// with ENTRY_NUM=2, DIM=2, 64-bit words.
module tb_act_pingpong_memory;

    logic        clk;
    logic        rst;
    logic        write;
    logic [15:0] index_entry, index_y, index_x;
    logic [63:0] in_data;
    logic        write_done;
    logic        write_ready;
    logic        wr_bank;
    logic [31:0] wr_count;
    logic        read_req;
    logic [15:0] read_index_entry, read_index_y, read_index_x;
    logic        read_done;
    logic        read_ready;
    logic        rd_bank;
    logic [63:0] out_data;
    logic        out_valid;
    logic [1:0]  err;

    int checks;
    int failures;

    act_pingpong_memory #(
        .NAME("TB MEM"),
        .ENTRY_NUM(2),
        .DIM(2),
        .DATA_SIZE(64),
        .DEBUG(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .write(write),
        .index_entry(index_entry),
        .index_y(index_y),
        .index_x(index_x),
        .in_data(in_data),
        .write_done(write_done),
        .write_ready(write_ready),
        .wr_bank(wr_bank),
        .wr_count(wr_count),
        .read_req(read_req),
        .read_index_entry(read_index_entry),
        .read_index_y(read_index_y),
        .read_index_x(read_index_x),
        .read_done(read_done),
        .read_ready(read_ready),
        .rd_bank(rd_bank),
        .out_data(out_data),
        .out_valid(out_valid),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rb(input int v);
        return $realtobits(real'(v));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst        = 1'b0;
        write      = 1'b0;
        write_done = 1'b0;
        read_req   = 1'b0;
        read_done  = 1'b0;
    endtask

    task automatic set_widx(input int f);
        index_entry = 16'(f / 4);
        index_y     = 16'((f / 2) % 2);
        index_x     = 16'(f % 2);
    endtask

    task automatic set_ridx(input int f);
        read_index_entry = 16'(f / 4);
        read_index_y     = 16'((f / 2) % 2);
        read_index_x     = 16'(f % 2);
    endtask

    task automatic fill_bank(input int base);
        for (int i = 0; i < 8; i++) begin
            write = 1'b1;
            set_widx(i);
            in_data = rb(i + base);
            step();
        end
        write = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (wr_bank !== 1'b0) begin failures++; $display("FAIL rst_wr_bank got=%0h exp=0", wr_bank); end
        checks++; if (rd_bank !== 1'b0) begin failures++; $display("FAIL rst_rd_bank got=%0h exp=0", rd_bank); end
        checks++; if (wr_count !== 32'd0) begin failures++; $display("FAIL rst_wr_count got=%0d exp=0", wr_count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
        checks++; if (out_data !== 64'd0) begin failures++; $display("FAIL rst_out_data got=%0h exp=0", out_data); end
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL rst_err got=%0b exp=00", err); end
        checks++; if (write_ready !== 1'b1) begin failures++; $display("FAIL rst_write_ready got=%0h exp=1", write_ready); end
        checks++; if (read_ready !== 1'b0) begin failures++; $display("FAIL rst_read_ready got=%0h exp=0", read_ready); end
    endtask

    task automatic test_read_not_ready();
        read_req = 1'b1;
        set_ridx(5);
        step();
        read_req = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL nr_out_valid got=%0h exp=0", out_valid); end
        checks++; if (out_data !== 64'd0) begin failures++; $display("FAIL nr_out_data got=%0h exp=0", out_data); end
        checks++; if (err !== 2'b10) begin failures++; $display("FAIL nr_err got=%0b exp=10", err); end
    endtask

    task automatic test_fill_bank0();
        fill_bank(0);
        checks++; if (wr_count !== 32'd8) begin failures++; $display("FAIL fill0_count got=%0d exp=8", wr_count); end
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        checks++; if (wr_bank !== 1'b1) begin failures++; $display("FAIL wd_wr_bank got=%0h exp=1", wr_bank); end
        checks++; if (read_ready !== 1'b1) begin failures++; $display("FAIL wd_read_ready got=%0h exp=1", read_ready); end
        checks++; if (wr_count !== 32'd0) begin failures++; $display("FAIL wd_wr_count got=%0d exp=0", wr_count); end
        checks++; if (write_ready !== 1'b1) begin failures++; $display("FAIL wd_write_ready got=%0h exp=1", write_ready); end
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL wd_err got=%0b exp=00", err); end
    endtask

    task automatic test_read();
        read_req = 1'b1;
        set_ridx(5);
        step();
        read_req = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rd_valid got=%0h exp=1", out_valid); end
        checks++; if (out_data !== rb(5)) begin failures++; $display("FAIL rd_data got=%0h exp=%0h", out_data, rb(5)); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_pulse got=%0h exp=0", out_valid); end
    endtask

    task automatic test_fill_while_read();
        for (int i = 0; i < 8; i++) begin
            write = 1'b1;
            set_widx(i);
            in_data = rb(i + 100);
            read_req = 1'b1;
            set_ridx(i);
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== rb(i)) begin
                failures++;
                $display("FAIL fwr_read%0d got=%0h/%0h exp=1/%0h", i, out_valid, out_data, rb(i));
            end
        end
        write = 1'b0;
        read_req = 1'b0;
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        checks++; if (wr_bank !== 1'b0) begin failures++; $display("FAIL full_wr_bank got=%0h exp=0", wr_bank); end
        checks++; if (write_ready !== 1'b0) begin failures++; $display("FAIL full_write_ready got=%0h exp=0", write_ready); end
        checks++; if (read_ready !== 1'b1) begin failures++; $display("FAIL full_read_ready got=%0h exp=1", read_ready); end
        write = 1'b1;
        set_widx(0);
        in_data = rb(77);
        step();
        write = 1'b0;
        checks++; if (err !== 2'b10) begin failures++; $display("FAIL stall_err got=%0b exp=10", err); end
        checks++; if (wr_count !== 32'd0) begin failures++; $display("FAIL stall_count got=%0d exp=0", wr_count); end
        read_req = 1'b1;
        set_ridx(0);
        step();
        read_req = 1'b0;
        checks++; if (out_data !== rb(0)) begin failures++; $display("FAIL stall_reread got=%0h exp=%0h", out_data, rb(0)); end
    endtask

    task automatic test_read_swap();
        read_req  = 1'b1;
        read_done = 1'b1;
        set_ridx(3);
        step();
        read_req  = 1'b0;
        read_done = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== rb(3)) begin failures++; $display("FAIL swap_read got=%0h/%0h exp=1/%0h", out_valid, out_data, rb(3)); end
        checks++; if (rd_bank !== 1'b1) begin failures++; $display("FAIL swap_rd_bank got=%0h exp=1", rd_bank); end
        checks++; if (write_ready !== 1'b1) begin failures++; $display("FAIL swap_write_ready got=%0h exp=1", write_ready); end
        write = 1'b1;
        set_widx(3);
        in_data = rb(9);
        step();
        write = 1'b0;
        checks++; if (out_data !== rb(3)) begin failures++; $display("FAIL swap_hold got=%0h exp=%0h", out_data, rb(3)); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL swap_pulse got=%0h exp=0", out_valid); end
        checks++; if (wr_count !== 32'd1) begin failures++; $display("FAIL swap_count got=%0d exp=1", wr_count); end
        read_req = 1'b1;
        set_ridx(3);
        step();
        read_req = 1'b0;
        checks++; if (out_data !== rb(103)) begin failures++; $display("FAIL bank1_read got=%0h exp=%0h", out_data, rb(103)); end
    endtask

    task automatic test_range();
        write = 1'b1;
        index_entry = 16'd0;
        index_y     = 16'd0;
        index_x     = 16'd2;
        in_data = rb(55);
        step();
        write = 1'b0;
        checks++; if (wr_count !== 32'd1) begin failures++; $display("FAIL oor_wr_count got=%0d exp=1", wr_count); end
        checks++; if (err !== 2'b11) begin failures++; $display("FAIL oor_wr_err got=%0b exp=11", err); end
        read_req = 1'b1;
        read_index_entry = 16'hFFFF;
        read_index_y     = 16'd0;
        read_index_x     = 16'd0;
        step();
        read_req = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL oor_rd_valid got=%0h exp=1", out_valid); end
        checks++; if (out_data !== 64'd0) begin failures++; $display("FAIL oor_rd_data got=%0h exp=0", out_data); end
    endtask

    task automatic test_wrap();
        read_done = 1'b1;
        step();
        read_done = 1'b0;
        checks++; if (rd_bank !== 1'b0) begin failures++; $display("FAIL wrap_rd_bank got=%0h exp=0", rd_bank); end
        checks++; if (read_ready !== 1'b0) begin failures++; $display("FAIL wrap_read_ready got=%0h exp=0", read_ready); end
    endtask

    task automatic test_reset_mid();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        fill_bank(0);
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            write = 1'b1;
            set_widx(i);
            in_data = rb(i + 200);
            step();
        end
        write = 1'b0;
        checks++; if (wr_count !== 32'd3 || wr_bank !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0d/%0h exp=3/1", wr_count, wr_bank); end
        rst      = 1'b1;
        write    = 1'b1;
        read_req = 1'b1;
        set_ridx(1);
        step();
        idle();
        checks++; if (wr_count !== 32'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", wr_count); end
        checks++; if (wr_bank !== 1'b0 || rd_bank !== 1'b0) begin failures++; $display("FAIL mid_banks got=%0h/%0h exp=0/0", wr_bank, rd_bank); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%0h exp=0", out_valid); end
        checks++; if (out_data !== 64'd0) begin failures++; $display("FAIL mid_out_data got=%0h exp=0", out_data); end
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL mid_err got=%0b exp=00", err); end
        checks++; if (write_ready !== 1'b1 || read_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%0h/%0h exp=1/0", write_ready, read_ready); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        write = 1'b0; write_done = 1'b0;
        read_req = 1'b0; read_done = 1'b0;
        index_entry = '0; index_y = '0; index_x = '0;
        read_index_entry = '0; read_index_y = '0; read_index_x = '0;
        in_data = '0;
        step();
        test_reset();
        test_read_not_ready();
        test_reset();
        test_fill_bank0();
        test_read();
        test_fill_while_read();
        test_read_swap();
        test_range();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
